// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bit and lane indices for the 16-bit core's pipeline registers.
package pipe_pkg;
   localparam int DEF_DATA_W     = 16;
   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_MEMTOREG  = 1;
   localparam int CTRL_MEMWRITE  = 2;
   localparam int CTRL_REGDST    = 3;
   localparam int CTRL_ALUOP_LSB = 4;
   localparam int CTRL_ALUOP_W   = 4;
   localparam int LANE_PC        = 0;
   localparam int LANE_DATA1     = 1;
   localparam int LANE_DATA2     = 2;
   localparam int LANE_INSTR     = 3;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+data+ctrl entry; clear beats load and returns ctrl to the safe value,
// while data is held so a bubble costs no data-path toggling.
module pipe_slot #(
   parameter int                W              = 64,
   parameter int                CTRL_W         = 8,
   parameter logic [CTRL_W-1:0] FLUSH_CTRL_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              clr_i,
   input  logic [W-1:0]      data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   output logic [W-1:0]      data_o,
   output logic [CTRL_W-1:0] ctrl_o
);
   logic              valid_q, valid_d;
   logic [W-1:0]      data_q, data_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;

   always_comb begin
      valid_d = clr_i ? 1'b0 : (load_i ? 1'b1 : valid_q);
      data_d  = (load_i & ~clr_i) ? data_i : data_q;
      ctrl_d  = clr_i ? FLUSH_CTRL_VAL : (load_i ? ctrl_i : ctrl_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= FLUSH_CTRL_VAL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready inter-stage register with flush bubbles and a saturating stall counter.
// Define PIPE_SKID_BUFFER_EN to add a skid entry and make in_ready a pure register output.
module pipe_stage_reg import pipe_pkg::*; #(
   parameter int                DATA_W         = DEF_DATA_W,
   parameter int                NUM_LANES      = 4,
   parameter int                CTRL_W         = 8,
   parameter logic [CTRL_W-1:0] FLUSH_CTRL_VAL = '0,
   parameter int                CNT_W          = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_LANES*DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0]           in_ctrl,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_LANES*DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0]           out_ctrl,
   output logic [CNT_W-1:0]            stall_count
);
   localparam int W = NUM_LANES * DATA_W;

   logic              out_fire, main_load, main_clr;
   logic [W-1:0]      main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign out_fire = out_valid & out_ready;

`ifdef PIPE_SKID_BUFFER_EN
   logic              skid_valid, acc, skid_load;
   logic [W-1:0]      skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   // in_ready can read 1 during a flush, so acceptance is gated here instead
   assign in_ready  = ~skid_valid;
   assign acc       = in_valid & in_ready & ~flush;
   assign skid_load = acc & out_valid & ~out_ready;
   assign main_load = skid_valid ? out_fire : acc & ~skid_load;
   assign main_data = skid_valid ? skid_data : in_data;
   assign main_ctrl = skid_valid ? skid_ctrl : in_ctrl;

   pipe_slot #(.W(W), .CTRL_W(CTRL_W), .FLUSH_CTRL_VAL(FLUSH_CTRL_VAL)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .clr_i   (flush | out_fire),
      .data_i  (in_data),
      .ctrl_i  (in_ctrl),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .ctrl_o  (skid_ctrl)
   );
`else
   assign in_ready  = ~flush & (~out_valid | out_ready);
   assign main_load = in_valid & in_ready;
   assign main_data = in_data;
   assign main_ctrl = in_ctrl;
`endif

   // a delivered entry with nothing behind it leaves a bubble
   assign main_clr = flush | (out_fire & ~main_load);

   pipe_slot #(.W(W), .CTRL_W(CTRL_W), .FLUSH_CTRL_VAL(FLUSH_CTRL_VAL)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load_i  (main_load),
      .clr_i   (main_clr),
      .data_i  (main_data),
      .ctrl_i  (main_ctrl),
      .valid_o (out_valid),
      .data_o  (out_data),
      .ctrl_o  (out_ctrl)
   );

   assign cnt_d = (out_valid & ~out_ready & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign stall_count = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized scoreboard bench; accepted beats queue up in order and the
// monitor pops one per delivered output, so the queue alone defines valid, order and stalls.
module tb_pipe_stage_reg;
   localparam int W  = 64;
   localparam int CW = 8;

   logic          clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic          in_ready, out_valid;
   logic [W-1:0]  in_data = '0, out_data;
   logic [CW-1:0] in_ctrl = '0, out_ctrl;
   logic [7:0]    stall_count;

   typedef struct packed {
      logic [W-1:0]  d;
      logic [CW-1:0] c;
   } ent_t;

   ent_t q[$];
   int   tests = 0, fails = 0, stall_m = 0;
   logic last_acc = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(16), .NUM_LANES(4), .CTRL_W(CW), .FLUSH_CTRL_VAL(8'h00), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_ctrl     (in_ctrl),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_ctrl    (out_ctrl),
      .stall_count (stall_count)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: mid-cycle, compares every presented output against the model
   always @(negedge clk) begin : monitor
      ent_t e;
      if (!rst) stall_m = 0;
      else begin
         chk("out_valid", {63'b0, out_valid}, {63'b0, q.size() != 0});
         if (!out_valid) chk("idle_ctrl", {56'b0, out_ctrl}, 64'h0);
         chk("stall_count", {56'b0, stall_count}, 64'(stall_m));
         if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_ctrl", {56'b0, out_ctrl}, {56'b0, e.c});
         end
         if (q.size() != 0 && !out_ready && stall_m < 255) stall_m++;
      end
   end

   // one cycle of stimulus: starts and ends 1 time unit after a rising edge
   task automatic step(input logic v, input logic [W-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
      logic exp_rdy;
      ent_t e;
      in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
      #1;
`ifdef PIPE_SKID_BUFFER_EN
      exp_rdy = q.size() < 2;
`else
      exp_rdy = !fl && (q.size() == 0 || ordy);
`endif
      chk("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
      last_acc = v && exp_rdy && !fl;
      @(posedge clk);
      if (fl) q.delete();
      if (last_acc) begin
         e.d = d; e.c = c;
         q.push_back(e);
      end
      #1;
   endtask

   function automatic logic [W-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      #3;
      chk("rst_valid", {63'b0, out_valid}, 64'h0);
      chk("rst_ctrl", {56'b0, out_ctrl}, 64'h0);
      chk("rst_data", out_data, 64'h0);
      chk("rst_stall", {56'b0, stall_count}, 64'h0);
      @(posedge clk); #1 rst = 1'b1;

      // pass-through of one beat
      step(1'b1, {16'hA3C5, 16'hBEEF, 16'h1234, 16'h0040}, 8'h05, 1'b1, 1'b0);
      chk("pt_lane_pc", {48'b0, out_data[15:0]}, 64'h0040);
      chk("pt_ctrl", {56'b0, out_ctrl}, 64'h05);
      step(1'b0, rnd64(), 8'hFF, 1'b1, 1'b0);
      chk("pt_bubble_valid", {63'b0, out_valid}, 64'h0);
      chk("pt_bubble_ctrl", {56'b0, out_ctrl}, 64'h0);

      // full throughput
      for (int i = 0; i < 16; i++) step(1'b1, rnd64(), 8'($urandom), 1'b1, 1'b0);
      step(1'b0, rnd64(), 8'h00, 1'b1, 1'b0);
      step(1'b0, rnd64(), 8'h00, 1'b1, 1'b0);
      chk("tp_stall", {56'b0, stall_count}, 64'h0);

      // flush with simultaneous input
      step(1'b1, rnd64(), 8'h03, 1'b0, 1'b0);
      step(1'b1, 64'hDEAD_BEEF_0000_0007, 8'h07, 1'b0, 1'b1);
      chk("flush_valid", {63'b0, out_valid}, 64'h0);
      chk("flush_ctrl", {56'b0, out_ctrl}, 64'h0);
      step(1'b0, rnd64(), 8'h00, 1'b1, 1'b0);

      // long stall saturates the counter
      step(1'b1, 64'h0123_4567_89AB_CDEF, 8'h1A, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step(1'($urandom), rnd64(), 8'($urandom), 1'b0, 1'b0);
      chk("stall_sat", {56'b0, stall_count}, 64'hFF);
      chk("stall_hold", out_data, 64'h0123_4567_89AB_CDEF);
      step(1'b0, rnd64(), 8'h00, 1'b1, 1'b0);
      step(1'b0, rnd64(), 8'h00, 1'b1, 1'b0);
      chk("stall_kept", {56'b0, stall_count}, 64'hFF);

      // asynchronous reset between edges while an entry is held
      step(1'b1, rnd64(), 8'h55, 1'b0, 1'b0);
      chk("pre_rst_valid", {63'b0, out_valid}, 64'h1);
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", {63'b0, out_valid}, 64'h0);
      chk("arst_ctrl", {56'b0, out_ctrl}, 64'h0);
      chk("arst_stall", {56'b0, stall_count}, 64'h0);
      q.delete();
      in_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;

`ifdef PIPE_SKID_BUFFER_EN
      step(1'b1, 64'h1, 8'h01, 1'b1, 1'b0);
      step(1'b1, 64'h2, 8'h02, 1'b1, 1'b0);
      step(1'b1, 64'h3, 8'h03, 1'b0, 1'b0);
      chk("skid_full_rdy", {63'b0, in_ready}, 64'h0);
      step(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
      chk("skid_ready_again", {63'b0, in_ready}, 64'h1);
`endif

      // randomized traffic with occasional flushes
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 9) < 7, rnd64(), 8'($urandom),
              $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      for (int i = 0; i < 3; i++) step(1'b0, rnd64(), 8'h00, 1'b1, 1'b0);
      chk("final_empty", {63'b0, out_valid}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
